digit_window_scroller: RTL

- Parametrised scrolling-window generator for the multi-digit 7-segment front end.
- Holds a buffer of NUM_DIGITS digits and presents a WINDOW-digit slice to the per-digit segment decoders.
- Slice position moves with the left/right push-buttons, or automatically on a tick.
- Supports wrap-around or saturating position, and ping-pong auto-scroll in saturating mode.

---
 rtl/digit_window_scroller.sv | 89 ++++++++
 1 files changed

// File: rtl/digit_window_scroller.sv
// digit_window_scroller: button/tick driven scrolling window over a digit buffer for the 7-segment front end.
module digit_window_scroller #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 8,
    parameter int WINDOW      = 4,
    parameter int WRAP        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             btn_left,
    input  logic                             btn_right,
    input  logic                             auto_en,
    input  logic                             tick,
    input  logic                             load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]    load_data,
    output logic [WINDOW*DIGIT_W-1:0]        window_out,
    output logic [$clog2(NUM_DIGITS)-1:0]    pos,
    output logic                             at_left,
    output logic                             at_right,
    output logic                             moved
);
    localparam int PW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] MAXP = PW'(NUM_DIGITS - WINDOW);
    localparam logic [PW-1:0] LAST = PW'(NUM_DIGITS - 1);

    typedef enum logic {RIGHT, LEFT} dir_t;

    dir_t                          dir, dir_n;
    logic [SYNC_STAGES-1:0]        sync_l, sync_r;
    logic                          prev_l, prev_r, step_l, step_r;
    logic                          auto_go, turn, go_r, go_l, mv_r, mv_l, changed;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [WINDOW*DIGIT_W-1:0]     win_n;
    logic [PW-1:0]                 pos_n;

    assign step_l  = sync_l[SYNC_STAGES-1] & ~prev_l;
    assign step_r  = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign auto_go = tick & auto_en & ~step_l & ~step_r;
    // ping-pong: at the far end the tick both reverses direction and steps back
    assign turn    = WRAP == 0 && MAXP != 0 && auto_go && (dir == RIGHT ? pos == MAXP : pos == '0);
    assign dir_n   = turn ? (dir == RIGHT ? LEFT : RIGHT) : dir;
    assign go_r    = (step_r & ~step_l) | (auto_go & (dir_n == RIGHT));
    assign go_l    = (step_l & ~step_r) | (auto_go & (dir_n == LEFT));
    assign mv_r    = go_r & (WRAP != 0 || pos != MAXP);
    assign mv_l    = go_l & (WRAP != 0 || pos != '0);
    assign pos_n   = mv_r ? (pos == LAST ? '0 : pos + PW'(1)) :
                     mv_l ? (pos == '0 ? LAST : pos - PW'(1)) : pos;
    assign at_left  = WRAP == 0 && pos == '0;
    assign at_right = WRAP == 0 && pos == MAXP;

    always_comb begin
        win_n = '0;
        for (int i = 0; i < WINDOW; i++)
            win_n[i*DIGIT_W +: DIGIT_W] = digits[((int'(pos) + i) % NUM_DIGITS)*DIGIT_W +: DIGIT_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_l     <= '0;
            sync_r     <= '0;
            prev_l     <= 1'b0;
            prev_r     <= 1'b0;
            digits     <= '0;
            pos        <= '0;
            dir        <= RIGHT;
            changed    <= 1'b0;
            moved      <= 1'b0;
            window_out <= '0;
        end else begin
            sync_l     <= {sync_l[SYNC_STAGES-2:0], btn_left};
            sync_r     <= {sync_r[SYNC_STAGES-2:0], btn_right};
            prev_l     <= sync_l[SYNC_STAGES-1];
            prev_r     <= sync_r[SYNC_STAGES-1];
            window_out <= win_n;
            moved      <= changed;
            if (load) begin
                digits  <= load_data;
                pos     <= '0;
                dir     <= RIGHT;
                changed <= 1'b1;
            end else begin
                pos     <= pos_n;
                dir     <= dir_n;
                changed <= mv_r | mv_l;
            end
        end
    end
endmodule
